aes_top: RTL and testbench
==========================

AES_TOP -- requirements
Module: aes_top

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port state, input, 128 bits: plaintext block; bit 127..120 = FIPS-197 byte 0, column-major byte order.
REQ-004 SHALL have port key, input, 128 bits: AES-128 cipher key, same byte order as state.
REQ-005 SHALL have port out, output, 128 bits, registered: ciphertext block, same byte order.
REQ-006 SHALL have no other ports and no parameters.

Function
REQ-007 SHALL implement AES-128 encryption per FIPS-197 (10 rounds; final round omits MixColumns); decryption out of scope.
REQ-008 SHALL be iterative, one round per clock, with a free-running round counter cnt cycling 0,1,...,10,0.
REQ-009 SHALL, at the edge where cnt==0, sample state and key, and load data register = state XOR key and round-key register = key.
REQ-010 SHALL, at edges where cnt==1..10, derive round key r=cnt combinationally from the previous round key (RotWord, SubWord, Rcon[r] = 01,02,04,08,10,20,40,80,1B,36) and set data = round(data) XOR roundkey_r.
REQ-011 SHALL, at the edge where cnt==10, load out with the final-round result; out SHALL hold that value until the next cnt==10 edge.
REQ-012 SHALL sample state/key only at cnt==0 edges; input changes at other times SHALL NOT affect the block in flight.
REQ-013 SHALL have latency of 11 rising edges from the sampling edge to the out update (inclusive); throughput one block per 11 cycles.
REQ-014 SHALL compute MixColumns with xtime (multiply by 02 modulo x^8+x^4+x^3+x+1) and SubBytes with the standard FIPS-197 S-box.
REQ-015 SHALL have no data-dependent timing and no hidden or alternate modes; out SHALL be a pure function of the sampled state and key.

Reset
REQ-016 SHALL, while rst==0, asynchronously force cnt=0, data register=0, round-key register=0 and out=0.
REQ-017 SHALL, on rst rising, start a fresh cycle: the first rising edge with rst==1 is a cnt==0 sampling edge.
REQ-018 SHALL discard any block in flight if reset is asserted mid-operation; out stays 0 until the next completed block.

Structure
REQ-019 SHALL place the Rcon table, round count (10) and block width (128) in a shared package aes_pkg.
REQ-020 SHALL use one sub-module aes_sbox (8-bit in, 8-bit out, combinational), instantiated 20 times: 16 for SubBytes, 4 for key-expansion SubWord.
REQ-021 SHALL keep ShiftRows, MixColumns and key expansion as combinational logic inside aes_top.

Verification
REQ-022 Reset held low several cycles -> out==0, cnt==0; rst released mid-cycle -> no glitch on out.
REQ-023 state=0, key=0 at the sampling edge -> after 11 edges out==66e94bd4ef8a2c3b884cfa59ca342b2e.
REQ-024 key=2b7e151628aed2a6abf7158809cf4f3c, state=3243f6a8885a308d313198a2e0370734 -> out==3925841d02dc09fbdc118597196a0b32.
REQ-025 key=000102030405060708090a0b0c0d0e0f, state=00112233445566778899aabbccddeeff -> out==69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-026 Change state/key at cnt==5 -> in-flight result unchanged; new inputs take effect only at the next cnt==0 edge.
REQ-027 Assert rst at cnt==6 then release -> out==0 until the next full 11-cycle block completes with the correct ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helper used by the iterative core.
package aes_pkg;

  localparam int BLK_W = 128;
  localparam int NR    = 10;

  // Last value of the free-running round counter (cnt runs 0..NR).
  localparam logic [3:0] CNT_LAST = 4'(NR);

  // Round constants indexed directly by the round counter; entry 0 and
  // entries above NR are never consumed.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Multiply by {02} modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encryptor: one round per clock, free-running 11-step
// counter. Byte i of a block sits at bits [127-8*i -: 8], column-major.
module aes_top
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] key,
  output logic [BLK_W-1:0] out
);

  logic [3:0]       cnt_q, cnt_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [BLK_W-1:0] rk_q, rk_d;
  logic [BLK_W-1:0] out_q, out_d;

  logic [BLK_W-1:0] sub_bytes, shifted, mixed, round_out, rk_next;
  logic [31:0]      rot_w, sub_w, temp_w;
  logic [31:0]      w0_n, w1_n, w2_n, w3_n;

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes, ShiftRows (row r rotates left by r columns) and MixColumns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      aes_sbox u_sbox (
        .in_i  (data_q[127-8*(4*c+r) -: 8]),
        .out_o (sub_bytes[127-8*(4*c+r) -: 8])
      );
      assign shifted[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mixed[127-32*c -: 32] = mix_col(shifted[127-32*c -: 32]);
  end

  // Key expansion: next round key from the current one, Rcon picked by cnt.
  assign rot_w = {rk_q[23:0], rk_q[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes_sbox u_ksbox (
      .in_i  (rot_w[31-8*j -: 8]),
      .out_o (sub_w[31-8*j -: 8])
    );
  end
  assign temp_w  = sub_w ^ {RCON[cnt_q], 24'h0};
  assign w0_n    = rk_q[127:96] ^ temp_w;
  assign w1_n    = rk_q[95:64] ^ w0_n;
  assign w2_n    = rk_q[63:32] ^ w1_n;
  assign w3_n    = rk_q[31:0] ^ w2_n;
  assign rk_next = {w0_n, w1_n, w2_n, w3_n};

  // The final round skips MixColumns.
  assign round_out = ((cnt_q == CNT_LAST) ? shifted : mixed) ^ rk_next;

  // Next-state: sample and whiten at cnt 0, one round per step, publish at the last.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    rk_d   = rk_q;
    out_d  = out_q;
    if (cnt_q == 4'd0) begin
      data_d = state ^ key;
      rk_d   = key;
      cnt_d  = 4'd1;
    end else begin
      data_d = round_out;
      rk_d   = rk_next;
      if (cnt_q == CNT_LAST) begin
        out_d = round_out;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // State registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      data_q <= '0;
      rk_q   <= '0;
      out_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rk_q   <= rk_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: byte-level AES model with a derived S-box,
// a phase model of the 11-edge schedule, and a per-cycle compare process.
module tb_aes_top;

  logic         clk;
  logic         rst;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;

  int total = 0;
  int bad   = 0;

  aes_top dut (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .key   (key),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    if (b == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  st [16];
    logic [7:0]  tmp [16];
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_tab[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) tmp[4*c+r] = st[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          st[4*c+0] = gmul(tmp[4*c], 2) ^ gmul(tmp[4*c+1], 3) ^ tmp[4*c+2] ^ tmp[4*c+3];
          st[4*c+1] = tmp[4*c] ^ gmul(tmp[4*c+1], 2) ^ gmul(tmp[4*c+2], 3) ^ tmp[4*c+3];
          st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ gmul(tmp[4*c+2], 2) ^ gmul(tmp[4*c+3], 3);
          st[4*c+3] = gmul(tmp[4*c], 3) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ gmul(tmp[4*c+3], 2);
        end else begin
          for (int r = 0; r < 4; r++) st[4*c+r] = tmp[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) st[i] ^= w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // Schedule model: phase counts edges since reset release, modulo 11.
  int           ph = 0;
  logic [127:0] cap_s = '0, cap_k = '0;
  logic [127:0] exp_out = '0;

  always @(posedge clk) begin
    if (rst) begin
      if (ph == 0) begin
        cap_s = state;
        cap_k = key;
      end
      if (ph == 10) exp_out = aes_ref(cap_s, cap_k);
      ph = (ph == 10) ? 0 : ph + 1;
    end else begin
      ph = 0;
      exp_out = '0;
    end
  end

  always @(negedge rst) begin
    ph = 0;
    exp_out = '0;
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (out !== exp_out) begin
        bad++;
        $display("FAIL out_vs_model t=%0t got=%h want=%h", $time, out, exp_out);
      end
      total++;
      if (dut.cnt_q !== 4'(ph)) begin
        bad++;
        $display("FAIL cnt_vs_model t=%0t got=%0d want=%0d", $time, dut.cnt_q, ph);
      end
    end
  end

  // out may only move on a rising clock edge while out of reset.
  time t_pos = 0;
  always @(posedge clk) t_pos = $time;
  always @(out) begin
    if (chk_en && rst === 1'b1 && $time != t_pos) begin
      total++;
      bad++;
      $display("FAIL out_glitch t=%0t got=%h", $time, out);
    end
  end

  task automatic wait_phase(input int p);
    int n = 0;
    while (ph != p && n < 15) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (ph != p) begin
      bad++;
      $display("FAIL wait_phase got=%0d want=%0d", ph, p);
    end
  endtask

  task automatic check_lit(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Present a block at the sampling edge, scramble inputs mid-flight, check result.
  task automatic run_block(input string name, input logic [127:0] s, input logic [127:0] k,
                           input logic [127:0] want);
    wait_phase(0);
    state = s;
    key   = k;
    wait_phase(5);
    state = {$urandom, $urandom, $urandom, $urandom};
    key   = {$urandom, $urandom, $urandom, $urandom};
    wait_phase(0);
    check_lit(name, out, want);
  endtask

  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K3 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    state = '0;
    key   = '0;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

    check_lit("model_zero", aes_ref('0, '0), C1);
    check_lit("model_fips", aes_ref(P2, K2), C2);
    check_lit("model_c1", aes_ref(P3, K3), C3);

    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    check_lit("reset_out", out, '0);
    #3 rst = 1'b1;

    run_block("vec_zero", '0, '0, C1);
    run_block("vec_fips", P2, K2, C2);
    run_block("vec_c1", P3, K3, C3);

    // Inputs change every cycle; only values present at sampling edges matter.
    for (int i = 0; i < 25 * 11; i++) begin
      @(negedge clk);
      #1;
      state = {$urandom, $urandom, $urandom, $urandom};
      key   = {$urandom, $urandom, $urandom, $urandom};
    end

    // Reset in the middle of a block, then a full clean block.
    wait_phase(0);
    state = P2;
    key   = K2;
    wait_phase(6);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_lit("reset_mid_out", out, '0);
    #3 rst = 1'b1;
    run_block("after_reset", P3, K3, C3);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
